// File: rtl/shift_pipe.sv
// Pipelined log barrel shifter (logical/arithmetic/rotate) with valid/ready on both sides.
// Optional out_carry port is enabled by defining SHIFT_PIPE_CARRY_EN.
module shift_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH),
    parameter int PIPE  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic             in_dir,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
`ifdef SHIFT_PIPE_CARRY_EN
    ,
    output logic             out_carry
`endif
);

    localparam int BASE  = SHW / PIPE;
    localparam int EXTRA = SHW % PIPE;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SHW-1:0]   amt;
        logic             dir;
        logic [1:0]       mode;
        logic             msb;
`ifdef SHIFT_PIPE_CARRY_EN
        logic             carry;
`endif
    } op_t;

    // First shifter level handled by stage k; earlier stages absorb the remainder levels.
    function automatic int stage_lo(input int k);
        return k * BASE + ((k < EXTRA) ? k : EXTRA);
    endfunction

    function automatic logic [WIDTH-1:0] level_shift(
        input logic [WIDTH-1:0] x,
        input int               lvl,
        input logic             dir,
        input logic [1:0]       mode,
        input logic             msb
    );
        int               sh;
        logic [WIDTH-1:0] r;
        sh = 1 << lvl;
        if (mode == 2'b10) begin
            r = dir ? ((x >> sh) | (x << (WIDTH - sh))) : ((x << sh) | (x >> (WIDTH - sh)));
        end else if (dir) begin
            r = x >> sh;
            if (mode == 2'b01 && msb)
                r = r | ~({WIDTH{1'b1}} >> sh);
        end else begin
            r = x << sh;
        end
        return r;
    endfunction

    logic [PIPE-1:0] valid;
    logic [PIPE-1:0] adv;
    logic [PIPE-1:0] src_valid;
    op_t             stage [PIPE];
    op_t             src   [PIPE];
    op_t             nxt   [PIPE];
    op_t             in_op;
    logic            zero_q;

    always_comb begin
        in_op      = '0;
        in_op.data = in_data;
        in_op.amt  = in_amt;
        in_op.dir  = in_dir;
        in_op.mode = in_mode;
        in_op.msb  = in_data[WIDTH-1];
`ifdef SHIFT_PIPE_CARRY_EN
        // The last bit shifted out depends only on the original operand, so resolve it up front.
        if (in_amt != '0 && in_mode != 2'b10) begin
            if (in_dir)
                in_op.carry = in_data[in_amt - SHW'(1)];
            else
                in_op.carry = in_data[SHW'(WIDTH - int'(in_amt))];
        end
`endif
    end

    always_comb begin
        src[0]       = in_op;
        src_valid[0] = in_valid;
        for (int k = 1; k < PIPE; k++) begin
            src[k]       = stage[k-1];
            src_valid[k] = valid[k-1];
        end
    end

    // Ready ripples back from the consumer so a full pipe can still move every cycle.
    always_comb begin
        adv         = '0;
        adv[PIPE-1] = !valid[PIPE-1] || out_ready;
        for (int k = PIPE - 2; k >= 0; k--)
            adv[k] = !valid[k] || adv[k+1];
    end

    assign in_ready = adv[0];

    always_comb begin
        for (int k = 0; k < PIPE; k++) begin
            nxt[k] = src[k];
            for (int i = 0; i < SHW; i++) begin
                if (i >= stage_lo(k) && i < stage_lo(k + 1) && src[k].amt[i])
                    nxt[k].data = level_shift(nxt[k].data, i, src[k].dir, src[k].mode, src[k].msb);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  <= '0;
            zero_q <= 1'b0;
            for (int k = 0; k < PIPE; k++)
                stage[k] <= '0;
        end else begin
            for (int k = 0; k < PIPE; k++) begin
                if (adv[k]) begin
                    valid[k] <= src_valid[k];
                    if (src_valid[k])
                        stage[k] <= nxt[k];
                end
            end
            if (adv[PIPE-1] && src_valid[PIPE-1])
                zero_q <= (nxt[PIPE-1].data == '0);
        end
    end

    assign out_valid = valid[PIPE-1];
    assign out_data  = stage[PIPE-1].data;
    assign out_zero  = zero_q;
`ifdef SHIFT_PIPE_CARRY_EN
    assign out_carry = stage[PIPE-1].carry;
`endif

endmodule

// File: tb/tb_shift_pipe.sv
// Directed testbench for shift_pipe (WIDTH=16, PIPE=2); covers out_carry when SHIFT_PIPE_CARRY_EN is defined.
module tb_shift_pipe;

    localparam int WIDTH = 16;
    localparam int SHW   = 4;
    localparam int PIPE  = 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_amt;
    logic             in_dir;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
`ifdef SHIFT_PIPE_CARRY_EN
    logic             out_carry;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    shift_pipe #(.WIDTH(WIDTH), .SHW(SHW), .PIPE(PIPE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_dir    (in_dir),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
`ifdef SHIFT_PIPE_CARRY_EN
        ,
        .out_carry (out_carry)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single request with the consumer always ready; result must appear after the second edge.
    task automatic apply_stimulus(input string tag, input logic [15:0] d, input logic [3:0] a,
                                  input logic dir, input logic [1:0] mode,
                                  input logic [15:0] exp, input logic cexp);
        in_data   = d;
        in_amt    = a;
        in_dir    = dir;
        in_mode   = mode;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check_output({tag, "_rdy"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check_output({tag, "_early"}, 32'(out_valid), 32'd0);
        step();
        check_output({tag, "_vld"}, 32'(out_valid), 32'd1);
        check_output({tag, "_data"}, 32'(out_data), 32'(exp));
        check_output({tag, "_zero"}, 32'(out_zero), 32'(exp == 16'h0));
`ifdef SHIFT_PIPE_CARRY_EN
        check_output({tag, "_carry"}, 32'(out_carry), 32'(cexp));
`else
        if (cexp === 1'bx) $display("[TB] unexpected X carry expectation in %s", tag);
`endif
        step();
    endtask

    function automatic logic [15:0] model(input logic [15:0] d, input logic [3:0] a,
                                          input logic dir, input logic [1:0] mode);
        int          ai;
        logic [31:0] w;
        ai = int'(a);
        w  = {16'h0, d};
        if (ai == 0) return d;
        case (mode)
            2'b10:   return dir ? 16'((w >> ai) | (w << (16 - ai))) : 16'((w << ai) | (w >> (16 - ai)));
            2'b01:   return dir ? 16'($signed(d) >>> ai) : 16'(w << ai);
            default: return dir ? 16'(w >> ai) : 16'(w << ai);
        endcase
    endfunction

    logic [15:0] vec_d    [8];
    logic [3:0]  vec_a    [8];
    logic        vec_dir  [8];
    logic [1:0]  vec_mode [8];
    logic [15:0] expq     [$];

    initial begin
        int          accepted;
        int          sent;
        int          got;
        int          stale;
        logic [15:0] pat;
        logic [15:0] exp;

        vec_d[0] = 16'hBEEF; vec_a[0] = 4'd3;  vec_dir[0] = 1'b1; vec_mode[0] = 2'b01;
        vec_d[1] = 16'h1234; vec_a[1] = 4'd5;  vec_dir[1] = 1'b0; vec_mode[1] = 2'b10;
        vec_d[2] = 16'h8001; vec_a[2] = 4'd1;  vec_dir[2] = 1'b1; vec_mode[2] = 2'b10;
        vec_d[3] = 16'hF0F0; vec_a[3] = 4'd8;  vec_dir[3] = 1'b1; vec_mode[3] = 2'b01;
        vec_d[4] = 16'h00FF; vec_a[4] = 4'd12; vec_dir[4] = 1'b0; vec_mode[4] = 2'b00;
        vec_d[5] = 16'hA5A5; vec_a[5] = 4'd0;  vec_dir[5] = 1'b1; vec_mode[5] = 2'b01;
        vec_d[6] = 16'h7FFF; vec_a[6] = 4'd15; vec_dir[6] = 1'b1; vec_mode[6] = 2'b01;
        vec_d[7] = 16'hC3C3; vec_a[7] = 4'd6;  vec_dir[7] = 1'b0; vec_mode[7] = 2'b11;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_dir    = 1'b0;
        in_mode   = 2'b00;
        out_ready = 1'b1;
        step();
        step();
        check_output("rst_valid", 32'(out_valid), 32'd0);
        check_output("rst_data", 32'(out_data), 32'd0);
        check_output("rst_zero", 32'(out_zero), 32'd0);
        rst_n = 1'b1;
        #1;
        check_output("rst_ready", 32'(in_ready), 32'd1);
        step();

        apply_stimulus("lsl2",   16'h5459, 4'd2,  1'b0, 2'b00, 16'h5164, 1'b1);
        apply_stimulus("lsr7",   16'h5459, 4'd7,  1'b1, 2'b00, 16'h00A8, 1'b1);
        apply_stimulus("asr15",  16'h8000, 4'd15, 1'b1, 2'b01, 16'hFFFF, 1'b0);
        apply_stimulus("lsr15",  16'h8000, 4'd15, 1'b1, 2'b00, 16'h0001, 1'b0);
        apply_stimulus("m11r15", 16'h8000, 4'd15, 1'b1, 2'b11, 16'h0001, 1'b0);
        apply_stimulus("asl3",   16'hC001, 4'd3,  1'b0, 2'b01, 16'h0008, 1'b0);
        apply_stimulus("ror4",   16'h5459, 4'd4,  1'b1, 2'b10, 16'h9545, 1'b0);
        apply_stimulus("rol4",   16'h5459, 4'd4,  1'b0, 2'b10, 16'h4595, 1'b0);
        apply_stimulus("amt0m0", 16'h5459, 4'd0,  1'b0, 2'b00, 16'h5459, 1'b0);
        apply_stimulus("amt0m1", 16'h5459, 4'd0,  1'b1, 2'b01, 16'h5459, 1'b0);
        apply_stimulus("amt0m2", 16'h5459, 4'd0,  1'b0, 2'b10, 16'h5459, 1'b0);
        apply_stimulus("amt0m3", 16'h5459, 4'd0,  1'b1, 2'b11, 16'h5459, 1'b0);
        apply_stimulus("zero",   16'h0001, 4'd1,  1'b1, 2'b00, 16'h0000, 1'b1);

        // Back-pressure: two requests fill the pipe, the third must wait.
        accepted  = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'b00;
        in_data = 16'h1111; in_amt = 4'd1; in_dir = 1'b0;
        #1;
        if (in_ready) accepted++;
        step();
        in_data = 16'h0101; in_amt = 4'd4; in_dir = 1'b0;
        #1;
        if (in_ready) accepted++;
        step();
        in_data = 16'h0F00; in_amt = 4'd8; in_dir = 1'b1;
        check_output("stall_rdy", 32'(in_ready), 32'd0);
        check_output("stall_vld", 32'(out_valid), 32'd1);
        check_output("stall_data", 32'(out_data), 32'h2222);
        step();
        step();
        check_output("stall_rdy2", 32'(in_ready), 32'd0);
        check_output("stall_hold", 32'(out_data), 32'h2222);
        check_output("stall_count", 32'(accepted), 32'd2);
        out_ready = 1'b1;
        #1;
        check_output("release_rdy", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check_output("release_b_vld", 32'(out_valid), 32'd1);
        check_output("release_b", 32'(out_data), 32'h1010);
        step();
        check_output("release_c_vld", 32'(out_valid), 32'd1);
        check_output("release_c", 32'(out_data), 32'h000F);
        step();
        check_output("release_empty", 32'(out_valid), 32'd0);

        // Back-to-back throughput with the consumer always ready.
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                in_valid = 1'b1;
                in_data  = 16'h0A0A + 16'(i);
                in_amt   = 4'd0;
                #1;
                check_output($sformatf("tput_rdy%0d", i), 32'(in_ready), 32'd1);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (i >= 1 && i <= 4) begin
                check_output($sformatf("tput_vld%0d", i), 32'(out_valid), 32'd1);
                check_output($sformatf("tput_data%0d", i), 32'(out_data), 32'(16'h0A0A + 16'(i - 1)));
            end
        end
        check_output("tput_drain", 32'(out_valid), 32'd0);

        // Stream with an irregular consumer; results must match the model in order.
        sent = 0;
        got  = 0;
        pat  = 16'b1011_0010_1110_0101;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            out_ready = pat[cyc % 16];
            if (sent < 8) begin
                in_valid = 1'b1;
                in_data  = vec_d[sent];
                in_amt   = vec_a[sent];
                in_dir   = vec_dir[sent];
                in_mode  = vec_mode[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                if (expq.size() > 0) begin
                    exp = expq.pop_front();
                    check_output($sformatf("stream%0d", got), 32'(out_data), 32'(exp));
                end else begin
                    check_output("stream_extra", 32'(out_data), 32'hDEAD_BEEF);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(in_data, in_amt, in_dir, in_mode));
                sent++;
            end
            step();
        end
        in_valid = 1'b0;
        check_output("stream_count", 32'(got), 32'd8);

        // Asynchronous reset with two operations in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = 16'hFFFF; in_amt = 4'd1; in_dir = 1'b0; in_mode = 2'b00;
        step();
        in_data = 16'h1234;
        step();
        in_valid = 1'b0;
        check_output("flight_vld", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("arst_vld", 32'(out_valid), 32'd0);
        check_output("arst_data", 32'(out_data), 32'd0);
        check_output("arst_zero", 32'(out_zero), 32'd0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check_output("arst_rdy", 32'(in_ready), 32'd1);
        stale = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (out_valid) stale++;
        end
        check_output("arst_stale", 32'(stale), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
